equal_pattern_gen: RTL and testbench

//  Producer side of the equal-halves counter: emits a burst of 4-bit words over valid/ready,

---
 rtl/equal_pattern_gen.sv | 173 +++++++++++++++++
 tb/tb_equal_pattern_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/equal_pattern_gen.sv
// Burst generator of 4-bit words with an exact count of equal-halves words (data_o[3:2]==data_o[1:0]).
// Optional abort input when EQ_PATTERN_GEN_ABORT_EN is defined.
module equal_pattern_gen #(
  parameter int         LEN_W     = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef EQ_PATTERN_GEN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] total_len,
  input  logic [LEN_W-1:0] target_eq,
  input  logic             ready_i,
  output logic [3:0]       data_o,
  output logic             valid_o,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] sent_cnt,
  output logic [LEN_W-1:0] eq_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [7:0]       lfsr, lfsr_next;
  logic [LEN_W-1:0] rem_w, rem_w_next;
  logic [LEN_W-1:0] rem_e, rem_e_next;
  logic             cur_eq, cur_eq_next;
  logic [3:0]       data_next;
  logic             valid_next, busy_next, done_next, err_next;
  logic [LEN_W-1:0] sent_next, eq_next;
  logic [LEN_W-1:0] rem_w_dec, rem_e_dec;

  // Returns {is_equal, word}. The k offset is forced nonzero so unequal halves really differ.
  function automatic logic [4:0] pick_word(input logic msb, input logic [3:0] low,
                                           input logic [LEN_W-1:0] rw,
                                           input logic [LEN_W-1:0] re);
    logic       eq;
    logic [1:0] r;
    logic [1:0] k;
    if (re == rw)
      eq = 1'b1;
    else if (re == '0)
      eq = 1'b0;
    else
      eq = msb;
    r = low[1:0];
    k = (low[3:2] == 2'b00) ? 2'b01 : low[3:2];
    return {eq, r, (eq ? r : (r ^ k))};
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always_comb begin
    state_next  = state;
    lfsr_next   = lfsr;
    rem_w_next  = rem_w;
    rem_e_next  = rem_e;
    cur_eq_next = cur_eq;
    data_next   = data_o;
    valid_next  = valid_o;
    busy_next   = busy;
    done_next   = 1'b0;
    err_next    = err;
    sent_next   = sent_cnt;
    eq_next     = eq_cnt;
    rem_w_dec   = rem_w - 1'b1;
    rem_e_dec   = rem_e - LEN_W'(cur_eq);

    case (state)
      IDLE: begin
        if (start) begin
          sent_next  = '0;
          eq_next    = '0;
          rem_w_next = total_len;
          rem_e_next = target_eq;
          busy_next  = 1'b1;
          if (target_eq > total_len) begin
            err_next   = 1'b1;
            done_next  = 1'b1;
            state_next = DONE;
          end else if (total_len == '0) begin
            err_next   = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            err_next   = 1'b0;
            valid_next = 1'b1;
            {cur_eq_next, data_next} = pick_word(lfsr[7], lfsr[3:0], total_len, target_eq);
            lfsr_next  = lfsr_step(lfsr);
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (valid_o && ready_i) begin
          sent_next  = sent_cnt + 1'b1;
          eq_next    = eq_cnt + LEN_W'(cur_eq);
          rem_w_next = rem_w_dec;
          rem_e_next = rem_e_dec;
          if (rem_w_dec != '0) begin
            {cur_eq_next, data_next} = pick_word(lfsr[7], lfsr[3:0], rem_w_dec, rem_e_dec);
            lfsr_next = lfsr_step(lfsr);
          end else begin
            valid_next = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
`ifdef EQ_PATTERN_GEN_ABORT_EN
        // Abort keeps the counters (including a same-cycle transfer) but loads no new word.
        if (abort) begin
          lfsr_next   = lfsr;
          data_next   = data_o;
          cur_eq_next = cur_eq;
          valid_next  = 1'b0;
          done_next   = 1'b1;
          err_next    = 1'b1;
          state_next  = DONE;
        end
`endif
      end

      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        valid_next = 1'b0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr     <= LFSR_SEED;
      rem_w    <= '0;
      rem_e    <= '0;
      cur_eq   <= 1'b0;
      data_o   <= 4'h0;
      valid_o  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sent_cnt <= '0;
      eq_cnt   <= '0;
    end else begin
      state    <= state_next;
      lfsr     <= lfsr_next;
      rem_w    <= rem_w_next;
      rem_e    <= rem_e_next;
      cur_eq   <= cur_eq_next;
      data_o   <= data_next;
      valid_o  <= valid_next;
      busy     <= busy_next;
      done     <= done_next;
      err      <= err_next;
      sent_cnt <= sent_next;
      eq_cnt   <= eq_next;
    end
  end

endmodule

// File: tb/tb_equal_pattern_gen.sv
// Directed bench for equal_pattern_gen; expected words derived by hand from the LFSR seed 8'hA5.
// Abort scenario is included when EQ_PATTERN_GEN_ABORT_EN is defined.
module tb_equal_pattern_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] total_len = 8'd0;
  logic [7:0] target_eq = 8'd0;
`ifdef EQ_PATTERN_GEN_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [3:0] data_o;
  logic       valid_o, busy, done, err;
  logic [7:0] sent_cnt, eq_cnt;

  equal_pattern_gen #(.LEN_W(8), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef EQ_PATTERN_GEN_ABORT_EN
    .abort(abort),
`endif
    .start(start), .total_len(total_len), .target_eq(target_eq), .ready_i(ready_i),
    .data_o(data_o), .valid_o(valid_o), .busy(busy), .done(done), .err(err),
    .sent_cnt(sent_cnt), .eq_cnt(eq_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  logic [3:0] words [16];
  logic [3:0] first_words [16];
  int nwords, neq, first_valid, done_cyc, stall_bad, diff;
  int err_done, sent_done, eq_done, done_after, busy_after, timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0;
    ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issues one command and follows it until done, recording every transferred word.
  task automatic run_burst(input int len, input int tgt, input bit toggle);
    logic [3:0] held;
    bit pend;
    int cyc;
    nwords = 0; neq = 0; first_valid = -1; done_cyc = -1; stall_bad = 0;
    pend = 1'b0; held = 4'h0;
    total_len = 8'(len);
    target_eq = 8'(tgt);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 200) begin
      if (done) begin
        done_cyc = cyc;
        err_done = int'(err);
        sent_done = int'(sent_cnt);
        eq_done = int'(eq_cnt);
      end
      if (valid_o) begin
        if (first_valid < 0) first_valid = cyc;
        if (pend && data_o !== held) stall_bad++;
        ready_i = toggle ? (cyc % 2 == 1) : 1'b1;
        if (ready_i) begin
          if (nwords < 16) words[nwords] = data_o;
          nwords++;
          if (data_o[3:2] == data_o[1:0]) neq++;
          pend = 1'b0;
        end else begin
          held = data_o;
          pend = 1'b1;
        end
      end
      if (done_cyc < 0) begin
        tick();
        cyc++;
      end
    end
    timeout = (done_cyc < 0) ? 1 : 0;
    ready_i = 1'b0;
    tick();
    done_after = int'(done);
    busy_after = int'(busy);
  endtask

  initial begin
    logic [3:0] exp_eq4 [4];
    logic [3:0] exp_ne5 [5];
    logic [3:0] held_word;
    exp_eq4 = '{4'h5, 4'hA, 4'h5, 4'hA};
    exp_ne5 = '{4'h1, 4'h7, 4'hE, 4'hE, 4'h9};

    // Reset state
    tick();
    tick();
    check("rst_data", data_o, 4'h0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sent", sent_cnt, 8'd0);
    check("rst_eq", eq_cnt, 8'd0);
    rst_n = 1'b1;
    tick();
    $display("step reset: outputs checked");

    // All-equal burst
    run_burst(4, 4, 1'b0);
    check("b1_timeout", timeout, 0);
    check("b1_nwords", nwords, 4);
    for (int i = 0; i < 4; i++) check($sformatf("b1_word%0d", i), words[i], exp_eq4[i]);
    check("b1_first_valid", first_valid, 1);
    check("b1_done_cyc", done_cyc, 5);
    check("b1_eq_cnt", eq_done, 4);
    check("b1_sent_cnt", sent_done, 4);
    check("b1_err", err_done, 0);
    check("b1_done_once", done_after, 0);
    check("b1_busy_after", busy_after, 0);
    $display("step len=4 tgt=4: %0d words", nwords);

    // All-unequal burst, LFSR continues from the previous command
    run_burst(5, 0, 1'b0);
    check("b2_nwords", nwords, 5);
    for (int i = 0; i < 5; i++) check($sformatf("b2_word%0d", i), words[i], exp_ne5[i]);
    check("b2_neq_seen", neq, 0);
    check("b2_sent_cnt", sent_done, 5);
    check("b2_eq_cnt", eq_done, 0);
    check("b2_done_once", done_after, 0);
    $display("step len=5 tgt=0: %0d words", nwords);

    // Impossible target, then a good command clears err
    run_burst(5, 6, 1'b0);
    check("b3_no_valid", first_valid, -1);
    check("b3_done_cyc", done_cyc, 1);
    check("b3_err", err_done, 1);
    check("b3_sent", sent_done, 0);
    check("b3_err_held", err, 1'b1);
    run_burst(1, 1, 1'b0);
    check("b4_err_cleared", err_done, 0);
    check("b4_word0", words[0], 4'h5);
    check("b4_eq_cnt", eq_done, 1);
    check("b4_done_cyc", done_cyc, 2);
    $display("step len=5 tgt=6 then len=1 tgt=1");

    // Start while busy is ignored; reset mid-burst aborts silently
    total_len = 8'd6; target_eq = 8'd2; ready_i = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("b5_valid", valid_o, 1'b1);
    held_word = data_o;
    tick();
    tick();
    total_len = 8'd2; target_eq = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("b5_ignore_valid", valid_o, 1'b1);
    check("b5_ignore_data", data_o, held_word);
    check("b5_ignore_sent", sent_cnt, 8'd0);
    check("b5_busy", busy, 1'b1);
    ready_i = 1'b1;
    tick(); tick(); tick();
    check("b5_sent3", sent_cnt, 8'd3);
    rst_n = 1'b0; ready_i = 1'b0;
    tick();
    check("b5_rst_data", data_o, 4'h0);
    check("b5_rst_valid", valid_o, 1'b0);
    check("b5_rst_busy", busy, 1'b0);
    check("b5_rst_done", done, 1'b0);
    check("b5_rst_sent", sent_cnt, 8'd0);
    check("b5_rst_eq", eq_cnt, 8'd0);
    rst_n = 1'b1;
    tick();
    check("b5_no_done", done, 1'b0);
    $display("step start-while-busy and mid-burst reset");

    // Stalling burst, twice from reset, must be reproducible
    reset_dut();
    run_burst(10, 3, 1'b1);
    for (int i = 0; i < 10; i++) first_words[i] = words[i];
    check("b6_timeout", timeout, 0);
    check("b6_nwords", nwords, 10);
    check("b6_stall_stable", stall_bad, 0);
    check("b6_sink_eq", neq, 3);
    check("b6_eq_cnt", eq_done, 3);
    check("b6_sent_cnt", sent_done, 10);
    reset_dut();
    run_burst(10, 3, 1'b1);
    diff = 0;
    for (int i = 0; i < 10; i++) if (words[i] !== first_words[i]) diff++;
    check("b6_repeat_diff", diff, 0);
    check("b6_repeat_eq", neq, 3);
    $display("step len=10 tgt=3 toggling ready, repeated");

`ifdef EQ_PATTERN_GEN_ABORT_EN
    reset_dut();
    total_len = 8'd8; target_eq = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    ready_i = 1'b1;
    tick(); tick(); tick();
    ready_i = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", valid_o, 1'b0);
    check("ab_done", done, 1'b1);
    check("ab_err", err, 1'b1);
    check("ab_sent", sent_cnt, 8'd3);
    tick();
    check("ab_done_pulse", done, 1'b0);
    $display("step abort after 3 transfers");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
